// File: rtl/cim_chip_sequencer.sv
// CIM chip operation sequencer: IDLE -> SETUP -> PULSE -> HOLD -> DONE around one chip access.
// Optional macro CIM_SEQ_BITSYNC_EN adds a 2-flop synchronizer on bit_in_i before capture.
module cim_chip_sequencer #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int HOLD_CYC  = 2
) (
  input  logic       clk_sys_in,
  input  logic       rst_sys_in,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [1:0] req_op_i,
  input  logic [4:0] req_col_i,
  input  logic [4:0] req_row_i,
  input  logic       req_wdata_i,
  output logic       rsp_valid_o,
  output logic [3:0] rsp_data_o,
  output logic       busy_o,
  output logic       cbl_o,
  output logic       cblen_o,
  output logic       csl_o,
  output logic       cwl_o,
  output logic [1:0] instr_o,
  output logic [4:0] addr_col_o,
  output logic [4:0] addr_row_o,
  input  logic [3:0] bit_in_i
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam logic [1:0] OP_PROG    = 2'b11;
  localparam logic [1:0] OP_READREG = 2'b01;
  localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD   = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYC - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       w_accept;
  logic       w_last_pulse;
  logic       w_pulse_next;
  logic [3:0] w_bit;

  logic [1:0] r_op;
  logic [4:0] r_col;
  logic [4:0] r_row;
  logic       r_wdata;
  logic       r_cbl;
  logic       r_cblen;
  logic       r_csl;
  logic       r_cwl;
  logic       r_rsp_valid;
  logic [3:0] r_rsp_data;

  always_ff @(posedge clk_sys_in or posedge rst_sys_in) begin
    if (rst_sys_in) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // One down-counter serves every timed state; it is reloaded on each transition.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid_i) begin
          w_accept     = 1'b1;
          w_state_next = ST_SETUP;
          w_cnt_next   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (r_cnt == 4'd0) begin
          w_state_next = ST_PULSE;
          w_cnt_next   = PULSE_LD;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_PULSE: begin
        if (r_cnt == 4'd0) begin
          w_state_next = ST_HOLD;
          w_cnt_next   = HOLD_LD;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == 4'd0) begin
          w_state_next = ST_DONE;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  assign w_last_pulse = (r_state == ST_PULSE) && (r_cnt == 4'd0);
  assign w_pulse_next = (w_state_next == ST_PULSE);

`ifdef CIM_SEQ_BITSYNC_EN
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;

  always_ff @(posedge clk_sys_in or posedge rst_sys_in) begin
    if (rst_sys_in) begin
      r_sync1 <= 4'd0;
      r_sync2 <= 4'd0;
    end else begin
      r_sync1 <= bit_in_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_bit = r_sync2;
`else
  assign w_bit = bit_in_i;
`endif

  // The request register doubles as the chip instr/address drivers, so the
  // values stay put from acceptance through DONE and into IDLE.
  always_ff @(posedge clk_sys_in or posedge rst_sys_in) begin
    if (rst_sys_in) begin
      r_op        <= 2'b00;
      r_col       <= 5'd0;
      r_row       <= 5'd0;
      r_wdata     <= 1'b0;
      r_cbl       <= 1'b0;
      r_cblen     <= 1'b0;
      r_csl       <= 1'b0;
      r_cwl       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 4'd0;
    end else begin
      if (w_accept) begin
        r_op    <= req_op_i;
        r_col   <= req_col_i;
        r_row   <= req_row_i;
        r_wdata <= req_wdata_i;
      end
      r_csl       <= w_pulse_next;
      r_cwl       <= w_pulse_next && (r_op != OP_READREG);
      r_cblen     <= w_pulse_next && (r_op == OP_PROG);
      r_cbl       <= w_pulse_next && (r_op == OP_PROG) && r_wdata;
      r_rsp_valid <= (w_state_next == ST_DONE);
      if (w_last_pulse && (r_op != OP_PROG)) begin
        r_rsp_data <= w_bit;
      end
    end
  end

  assign req_ready_o = (r_state == ST_IDLE) && !rst_sys_in;
  assign busy_o      = (r_state != ST_IDLE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign cbl_o       = r_cbl;
  assign cblen_o     = r_cblen;
  assign csl_o       = r_csl;
  assign cwl_o       = r_cwl;
  assign instr_o     = r_op;
  assign addr_col_o  = r_col;
  assign addr_row_o  = r_row;

endmodule

// File: tb/tb_cim_chip_sequencer.sv
// Directed self-checking bench for cim_chip_sequencer at default timing (2/4/2).
module tb_cim_chip_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [4:0] req_col = 5'd0;
  logic [4:0] req_row = 5'd0;
  logic       req_wdata = 1'b0;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       busy;
  logic       cbl, cblen, csl, cwl;
  logic [1:0] instr;
  logic [4:0] addr_col, addr_row;
  logic [3:0] bit_in = 4'b0000;

  int errors = 0;
  int checks = 0;

  // per-operation observations filled by run_op
  int n_csl, n_cwl, n_cbl, n_cblen, n_rv, rv_k, first_csl, addr_bad;
  logic busy0, ready9;

  always #5 clk = ~clk;

  cim_chip_sequencer dut (
    .clk_sys_in (clk),
    .rst_sys_in (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_op_i   (req_op),
    .req_col_i  (req_col),
    .req_row_i  (req_row),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_data_o (rsp_data),
    .busy_o     (busy),
    .cbl_o      (cbl),
    .cblen_o    (cblen),
    .csl_o      (csl),
    .cwl_o      (cwl),
    .instr_o    (instr),
    .addr_col_o (addr_col),
    .addr_row_o (addr_row),
    .bit_in_i   (bit_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one request, scrambles the request inputs right after acceptance,
  // and samples outputs on the falling edge after each of rising edges 0..10
  // (k = edges since acceptance). A pulse seen at k=8 is taken by edge 9.
  task automatic run_op(input logic [1:0] op, input logic [4:0] col, input logic [4:0] row,
                        input logic wd, input int tog_k, input logic [3:0] tog_val);
    @(negedge clk);
    req_op = op; req_col = col; req_row = row; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = ~op; req_col = ~col; req_row = ~row; req_wdata = ~wd;
    n_csl = 0; n_cwl = 0; n_cbl = 0; n_cblen = 0; n_rv = 0; rv_k = -1;
    first_csl = -1; addr_bad = 0; busy0 = 1'b0; ready9 = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      n_csl += int'(csl); n_cwl += int'(cwl); n_cbl += int'(cbl); n_cblen += int'(cblen);
      if (csl && first_csl < 0) first_csl = k;
      if (k <= 8 && (instr !== op || addr_col !== col || addr_row !== row)) addr_bad++;
      if (k == 0) busy0 = busy;
      if (k == 9) ready9 = req_ready;
      if (rsp_valid) begin n_rv++; rv_k = k; end
      if (k == tog_k) bit_in = tog_val;
    end
  endtask

  int acc_cnt, rv_cnt;
  int acc_edge [3];

  initial begin
    // reset state
    #12;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_strobes", {28'd0, cbl, cblen, csl, cwl}, 0);
    chk("rst_rsp", {27'd0, rsp_valid, rsp_data}, 0);
    chk("rst_instr_addr", {20'd0, instr, addr_col, addr_row}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(req_ready), 1);

    // read_mem col=5 row=17 with 1010 held
    bit_in = 4'b1010;
    run_op(2'b10, 5'd5, 5'd17, 1'b0, -1, 4'b0000);
    chk("rdm_busy0", 32'(busy0), 1);
    chk("rdm_addr_hold", 32'(addr_bad), 0);
    chk("rdm_csl_cnt", 32'(n_csl), 4);
    chk("rdm_cwl_cnt", 32'(n_cwl), 4);
    chk("rdm_cbl_cblen", 32'(n_cbl + n_cblen), 0);
    chk("rdm_csl_start", 32'(first_csl), 2);
    chk("rdm_rv_cnt", 32'(n_rv), 1);
    chk("rdm_rv_edge", 32'(rv_k + 1), 9);
    chk("rdm_ready9", 32'(ready9), 1);
    chk("rdm_data", 32'(rsp_data), 32'hA);

    // prog wdata=1 col=31 row=0; data must not be captured
    bit_in = 4'b0101;
    run_op(2'b11, 5'd31, 5'd0, 1'b1, -1, 4'b0000);
    chk("prg_addr_hold", 32'(addr_bad), 0);
    chk("prg_cbl_cnt", 32'(n_cbl), 4);
    chk("prg_cblen_cnt", 32'(n_cblen), 4);
    chk("prg_cwl_cnt", 32'(n_cwl), 4);
    chk("prg_csl_cnt", 32'(n_csl), 4);
    chk("prg_rv_cnt", 32'(n_rv), 1);
    chk("prg_data_kept", 32'(rsp_data), 32'hA);

    // read_reg: csl only
    bit_in = 4'b0110;
    run_op(2'b01, 5'd12, 5'd3, 1'b0, -1, 4'b0000);
    chk("rdr_csl_cnt", 32'(n_csl), 4);
    chk("rdr_cwl_cnt", 32'(n_cwl), 0);
    chk("rdr_rv_edge", 32'(rv_k + 1), 9);
    chk("rdr_data", 32'(rsp_data), 32'h6);

    // inference, bit_in rises one cycle before the last PULSE cycle
    bit_in = 4'b0000;
    run_op(2'b00, 5'd9, 5'd22, 1'b0, 4, 4'b1111);
    chk("inf_csl_cnt", 32'(n_csl), 4);
    chk("inf_cwl_cnt", 32'(n_cwl), 4);
    chk("inf_cbl_cblen", 32'(n_cbl + n_cblen), 0);
    chk("inf_addr_hold", 32'(addr_bad), 0);
`ifdef CIM_SEQ_BITSYNC_EN
    chk("inf_sync_data", 32'(rsp_data), 32'h0);
`else
    chk("inf_direct_data", 32'(rsp_data), 32'hF);
`endif

    // read_reg with valid held for 30 edges: accepts at edges 0, 10, 20
    @(negedge clk);
    req_op = 2'b01; req_col = 5'd1; req_row = 5'd2; req_valid = 1'b1;
    acc_cnt = 0; rv_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready) begin
        if (acc_cnt < 3) acc_edge[acc_cnt] = i;
        acc_cnt++;
      end
      if (rsp_valid) rv_cnt++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("hold_acc_cnt", 32'(acc_cnt), 3);
    chk("hold_rv_cnt", 32'(rv_cnt), 3);
    chk("hold_spacing1", 32'(acc_edge[1] - acc_edge[0]), 10);
    chk("hold_spacing2", 32'(acc_edge[2] - acc_edge[1]), 10);

    // reset in the middle of an inference PULSE
    repeat (3) @(negedge clk);
    req_op = 2'b00; req_col = 5'd7; req_row = 5'd8; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_in_pulse", {30'd0, csl, cwl}, 3);
    rst = 1'b1;
    #1;
    chk("abort_strobes", {28'd0, cbl, cblen, csl, cwl}, 0);
    chk("abort_busy_ready", {30'd0, busy, req_ready}, 0);
    chk("abort_rsp", {27'd0, rsp_valid, rsp_data}, 0);
    chk("abort_instr_addr", {20'd0, instr, addr_col, addr_row}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready_rel", 32'(req_ready), 1);
    rv_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) rv_cnt++;
    end
    chk("abort_no_rsp", 32'(rv_cnt), 0);
    chk("abort_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
